// File: rtl/cmac_usplus_0_axis_pkt_chk.sv
// cmac_usplus_0_axis_pkt_chk
// Receive-side frame checker for the CMAC AXI-Stream RX user interface.
// Waits for lane alignment, then counts incoming frames as good or bad
// (length, error flag, keep shape) until PKT_NUM frames have been seen.
//
// Ports:
//   clk, reset             RX user clock, async active-high reset
//   stat_rx_aligned        CMAC lane alignment status
//   lbus_tx_rx_restart_in  single-cycle restart request (WAIT_ALIGN/DONE only)
//   rx_axis_*              AXI-Stream beat (no tready, never backpressured)
//   ctl_rx_enable          CMAC RX enable, high outside IDLE
//   rx_prestate            state encoding for debug
//   good_pkt_cnt/bad_pkt_cnt/rx_byte_cnt  per-run statistics
//   rx_*_led, rx_align_lost               status flags
//
// Optional feature: define CMAC_RX_PATTERN_CHK_EN to also require that
// frame byte n carries the value n[7:0].
//
// state      | meaning
// IDLE       | held in reset / first cycle after reset release
// WAIT_ALIGN | RX enabled, waiting for lane alignment
// RX_PKT     | consuming and checking frames
// DONE       | PKT_NUM frames counted, beats ignored
module cmac_usplus_0_axis_pkt_chk #(
  parameter int PKT_NUM  = 1000,
  parameter int PKT_SIZE = 522
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stat_rx_aligned,
  input  logic         lbus_tx_rx_restart_in,
  input  logic         rx_axis_tvalid,
  input  logic [511:0] rx_axis_tdata,
  input  logic [63:0]  rx_axis_tkeep,
  input  logic         rx_axis_tlast,
  input  logic         rx_axis_tuser,
  output logic         ctl_rx_enable,
  output logic [3:0]   rx_prestate,
  output logic [15:0]  good_pkt_cnt,
  output logic [15:0]  bad_pkt_cnt,
  output logic [31:0]  rx_byte_cnt,
  output logic         rx_aligned_led,
  output logic         rx_busy_led,
  output logic         rx_done_led,
  output logic         rx_data_fail_led,
  output logic         rx_align_lost
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WAIT_ALIGN = 4'd1,
    RX_PKT     = 4'd2,
    DONE       = 4'd3
  } state_t;

  state_t state, state_nxt;

  logic [13:0] len_acc;     // bytes of the completed (non-last) beats so far
  logic        frame_err;   // error seen on an earlier beat of this frame
  logic [6:0]  keep_ones;
  logic        keep_contig;
  logic [14:0] len_sum;
  logic [13:0] len_next;
  logic        beat_err;
  logic        pattern_err;
  logic        beat;
  logic        align_drop;
  logic        restart;
  logic        verdict_fire;
  logic        verdict_good;
  logic [16:0] pkt_total;
  logic        run_done;

  assign beat       = (state == RX_PKT) && stat_rx_aligned && rx_axis_tvalid;
  assign align_drop = (state == RX_PKT) && !stat_rx_aligned;
  assign restart    = lbus_tx_rx_restart_in && ((state == WAIT_ALIGN) || (state == DONE));

  always_comb begin
    keep_ones = '0;
    for (int k = 0; k < 64; k++) keep_ones = keep_ones + 7'(rx_axis_tkeep[k]);
  end

  // Contiguous from bit 0 means tkeep+1 is a single power of two.
  assign keep_contig = (rx_axis_tkeep != 64'd0) &&
                       ((rx_axis_tkeep & (rx_axis_tkeep + 64'd1)) == 64'd0);

  assign len_sum  = {1'b0, len_acc} + (rx_axis_tlast ? {8'd0, keep_ones} : 15'd64);
  assign len_next = len_sum[14] ? 14'h3FFF : len_sum[13:0];

`ifdef CMAC_RX_PATTERN_CHK_EN
  // len_acc is the frame offset of byte 0 of this beat.
  always_comb begin
    pattern_err = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (rx_axis_tkeep[k] && (rx_axis_tdata[8*k +: 8] != (len_acc[7:0] + 8'(k))))
        pattern_err = 1'b1;
    end
  end
`else
  logic unused_tdata;
  assign unused_tdata = ^rx_axis_tdata;
  assign pattern_err  = 1'b0;
`endif

  assign beat_err = pattern_err |
                    (rx_axis_tlast ? (!keep_contig || rx_axis_tuser) : !(&rx_axis_tkeep));

  assign verdict_fire = beat && rx_axis_tlast;
  assign verdict_good = !frame_err && !beat_err && (len_next == 14'(PKT_SIZE));
  assign pkt_total    = {1'b0, good_pkt_cnt} + {1'b0, bad_pkt_cnt} + 17'd1;
  assign run_done     = verdict_fire && (pkt_total == 17'(PKT_NUM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ctl_rx_enable = 1'b1;
    rx_busy_led   = 1'b0;
    rx_done_led   = 1'b0;
    unique case (state)
      IDLE: begin
        ctl_rx_enable = 1'b0;
        state_nxt     = WAIT_ALIGN;
      end
      WAIT_ALIGN: begin
        if (restart)              state_nxt = WAIT_ALIGN;
        else if (stat_rx_aligned) state_nxt = RX_PKT;
      end
      RX_PKT: begin
        rx_busy_led = 1'b1;
        if (align_drop)    state_nxt = WAIT_ALIGN;
        else if (run_done) state_nxt = DONE;
      end
      DONE: begin
        rx_done_led = 1'b1;
        if (restart) state_nxt = WAIT_ALIGN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_prestate = state;

  // Per-frame accumulation; anything outside RX_PKT discards a partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_acc   <= '0;
      frame_err <= 1'b0;
    end else if ((state != RX_PKT) || align_drop || verdict_fire) begin
      len_acc   <= '0;
      frame_err <= 1'b0;
    end else if (beat) begin
      len_acc   <= len_next;
      frame_err <= frame_err | beat_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_pkt_cnt     <= '0;
      bad_pkt_cnt      <= '0;
      rx_byte_cnt      <= '0;
      rx_data_fail_led <= 1'b0;
      rx_align_lost    <= 1'b0;
      rx_aligned_led   <= 1'b0;
    end else begin
      rx_aligned_led <= stat_rx_aligned;
      if (restart) begin
        good_pkt_cnt     <= '0;
        bad_pkt_cnt      <= '0;
        rx_byte_cnt      <= '0;
        rx_data_fail_led <= 1'b0;
        rx_align_lost    <= 1'b0;
      end else begin
        if (verdict_fire) begin
          if (verdict_good) begin
            good_pkt_cnt <= good_pkt_cnt + 16'd1;
            rx_byte_cnt  <= rx_byte_cnt + {18'd0, len_next};
          end else begin
            bad_pkt_cnt      <= bad_pkt_cnt + 16'd1;
            rx_data_fail_led <= 1'b1;
          end
        end
        if (align_drop) rx_align_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmac_usplus_0_axis_pkt_chk.sv
module tb_cmac_usplus_0_axis_pkt_chk;

  localparam int PKT_NUM  = 3;
  localparam int PKT_SIZE = 522;
`ifdef CMAC_RX_PATTERN_CHK_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         aligned;
  logic         restart;
  logic         tvalid;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic         tuser;
  logic         ctl_rx_enable;
  logic [3:0]   rx_prestate;
  logic [15:0]  good_cnt, bad_cnt;
  logic [31:0]  byte_cnt;
  logic         aligned_led, busy_led, done_led, fail_led, align_lost;

  int n_cmp = 0;
  int n_err = 0;
  bit skip_wait = 1'b0;
  bit restart_on_last = 1'b0;

  always #5 clk = ~clk;

  cmac_usplus_0_axis_pkt_chk #(.PKT_NUM(PKT_NUM), .PKT_SIZE(PKT_SIZE)) dut (
    .clk                   (clk),
    .reset                 (rst),
    .stat_rx_aligned       (aligned),
    .lbus_tx_rx_restart_in (restart),
    .rx_axis_tvalid        (tvalid),
    .rx_axis_tdata         (tdata),
    .rx_axis_tkeep         (tkeep),
    .rx_axis_tlast         (tlast),
    .rx_axis_tuser         (tuser),
    .ctl_rx_enable         (ctl_rx_enable),
    .rx_prestate           (rx_prestate),
    .good_pkt_cnt          (good_cnt),
    .bad_pkt_cnt           (bad_cnt),
    .rx_byte_cnt           (byte_cnt),
    .rx_aligned_led        (aligned_led),
    .rx_busy_led           (busy_led),
    .rx_done_led           (done_led),
    .rx_data_fail_led      (fail_led),
    .rx_align_lost         (align_lost)
  );

  typedef struct {
    string       name;
    int          nbytes;
    bit          user;
    int          gap;
    int          corrupt;
    bit          hole;
    bit          ovr;
    logic [63:0] ovr_keep;
    int          exp_good;
    int          exp_bad;
    int          exp_bytes;
    bit          exp_fail;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input string name, input int nbytes, input bit user,
                              input int gap, input int corrupt, input bit hole,
                              input bit ovr, input logic [63:0] ovr_keep,
                              input int eg, input int eb, input int ebytes, input bit ef);
    vec_t v;
    v.name = name; v.nbytes = nbytes; v.user = user; v.gap = gap;
    v.corrupt = corrupt; v.hole = hole; v.ovr = ovr; v.ovr_keep = ovr_keep;
    v.exp_good = eg; v.exp_bad = eb; v.exp_bytes = ebytes; v.exp_fail = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = 1'b0; restart = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    aligned = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_rx();
    int i;
    for (i = 0; i < 20; i++) begin
      if (rx_prestate == 4'd2) break;
      @(posedge clk); #1;
    end
    if (i == 20) begin
      n_cmp++; n_err++;
      $display("FAIL wait_rx_pkt: timed out, state %0d", rx_prestate);
    end
  endtask

  // Returns at #1 after the edge that sampled the last (or aborting) beat.
  task automatic send_frame(input int nbytes, input bit user, input int gap,
                            input int corrupt, input bit hole, input bit ovr,
                            input logic [63:0] ovr_keep, input int abort_at);
    int beats, rem, off;
    logic [511:0] d;
    logic [63:0]  k;
    beats = (nbytes + 63) / 64;
    if (!skip_wait) wait_rx();
    for (int b = 0; b < beats; b++) begin
      for (int i = 0; i < 64; i++) begin
        off = b * 64 + i;
        d[8*i +: 8] = (off == corrupt) ? 8'hFF : 8'(off);
      end
      rem = nbytes - b * 64;
      if (b == beats - 1) k = (rem >= 64) ? '1 : ((64'd1 << rem) - 64'd1);
      else                k = '1;
      if (b == beats - 1 && ovr) k = ovr_keep;
      if (b == 0 && hole && beats > 1) k[5] = 1'b0;
      tvalid = 1'b1; tdata = d; tkeep = k;
      tlast  = (b == beats - 1);
      tuser  = (b == beats - 1) && user;
      if (b == abort_at) aligned = 1'b0;
      if ((b == beats - 1) && restart_on_last) restart = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      if (b == abort_at) return;
      if (b == 2 && gap > 0) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic good_frame();
    send_frame(PKT_SIZE, 1'b0, 0, -1, 1'b0, 1'b0, 64'd0, -1);
  endtask

  initial begin
    vecs[0] = mk("good522",   522, 0, 0, -1,  0, 0, 64'd0,     1, 0, 522, 0);
    vecs[1] = mk("short521",  521, 0, 0, -1,  0, 0, 64'd0,     0, 1, 0,   1);
    vecs[2] = mk("long523",   523, 0, 0, -1,  0, 0, 64'd0,     0, 1, 0,   1);
    vecs[3] = mk("tuser",     522, 1, 0, -1,  0, 0, 64'd0,     0, 1, 0,   1);
    vecs[4] = mk("gap3",      522, 0, 3, -1,  0, 0, 64'd0,     1, 0, 522, 0);
    vecs[5] = mk("midhole",   522, 0, 0, -1,  1, 0, 64'd0,     0, 1, 0,   1);
    vecs[6] = mk("noncontig", 522, 0, 0, -1,  0, 1, 64'h7FE,   0, 1, 0,   1);
    vecs[7] = mk("zerokeep",  522, 0, 0, -1,  0, 1, 64'h0,     0, 1, 0,   1);
    vecs[8] = mk("corrupt",   522, 0, 0, 100, 0, 0, 64'd0,
                 PAT ? 0 : 1, PAT ? 1 : 0, PAT ? 0 : 522, PAT);
    vecs[9] = mk("onebeat64", 64,  0, 0, -1,  0, 0, 64'd0,     0, 1, 0,   1);

    // Reset values and the IDLE -> WAIT_ALIGN -> RX_PKT walk
    rst = 1'b1; idle_inputs(); aligned = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_state", rx_prestate, 0);
    check("rst_ctl_en", ctl_rx_enable, 0);
    check("rst_counts", {good_cnt, bad_cnt} | byte_cnt, 0);
    check("rst_leds", {aligned_led, busy_led, done_led, fail_led, align_lost}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_state", rx_prestate, 1);
    check("post_rst_ctl_en", ctl_rx_enable, 1);
    @(posedge clk); #1;
    check("rx_state", rx_prestate, 2);
    check("busy_led", busy_led, 1);
    check("aligned_led", aligned_led, 1);

    // Single-frame vectors, each from a fresh reset
    foreach (vecs[i]) begin
      do_reset();
      send_frame(vecs[i].nbytes, vecs[i].user, vecs[i].gap, vecs[i].corrupt,
                 vecs[i].hole, vecs[i].ovr, vecs[i].ovr_keep, -1);
      check({vecs[i].name, "_good"},  good_cnt, vecs[i].exp_good);
      check({vecs[i].name, "_bad"},   bad_cnt,  vecs[i].exp_bad);
      check({vecs[i].name, "_bytes"}, byte_cnt, vecs[i].exp_bytes);
      check({vecs[i].name, "_fail"},  fail_led, vecs[i].exp_fail);
    end

    // Two good frames; restart in RX_PKT is ignored
    do_reset();
    good_frame();
    good_frame();
    check("two_good", good_cnt, 2);
    check("two_bad", bad_cnt, 0);
    check("two_bytes", byte_cnt, 1044);
    check("two_fail", fail_led, 0);
    restart = 1'b1; @(posedge clk); #1; restart = 1'b0;
    check("restart_in_rx_good", good_cnt, 2);
    check("restart_in_rx_state", rx_prestate, 2);

    // tuser frame then gapped good frame whose tlast coincides with restart
    do_reset();
    send_frame(PKT_SIZE, 1'b1, 0, -1, 1'b0, 1'b0, 64'd0, -1);
    restart_on_last = 1'b1;
    send_frame(PKT_SIZE, 1'b0, 3, -1, 1'b0, 1'b0, 64'd0, -1);
    restart_on_last = 1'b0;
    check("mix_bad", bad_cnt, 1);
    check("mix_good", good_cnt, 1);
    check("mix_bytes", byte_cnt, 522);
    check("mix_state", rx_prestate, 2);

    // Alignment lost on beat 4 of 9, then a full frame after realign
    do_reset();
    send_frame(PKT_SIZE, 1'b0, 0, -1, 1'b0, 1'b0, 64'd0, 3);
    check("drop_good", good_cnt, 0);
    check("drop_bad", bad_cnt, 0);
    check("drop_lost", align_lost, 1);
    check("drop_state", rx_prestate, 1);
    check("drop_aligned_led", aligned_led, 0);
    aligned = 1'b1;
    good_frame();
    check("realign_good", good_cnt, 1);
    check("realign_bad", bad_cnt, 0);
    check("realign_lost_sticky", align_lost, 1);

    // PKT_NUM=3: done after the third, fourth ignored, restart clears
    do_reset();
    good_frame();
    good_frame();
    check("pre_done_led", done_led, 0);
    good_frame();
    check("done_led", done_led, 1);
    check("done_state", rx_prestate, 3);
    check("done_busy", busy_led, 0);
    skip_wait = 1'b1;
    good_frame();
    skip_wait = 1'b0;
    check("done_ignore_good", good_cnt, 3);
    check("done_ignore_bytes", byte_cnt, 1566);
    restart = 1'b1; @(posedge clk); #1; restart = 1'b0;
    check("restart_counts", {good_cnt, bad_cnt} | byte_cnt, 0);
    check("restart_state", rx_prestate, 1);
    check("restart_done_led", done_led, 0);

    // Restart also clears sticky flags from WAIT_ALIGN
    do_reset();
    send_frame(521, 1'b0, 0, -1, 1'b0, 1'b0, 64'd0, -1);
    send_frame(PKT_SIZE, 1'b0, 0, -1, 1'b0, 1'b0, 64'd0, 2);
    restart = 1'b1; @(posedge clk); #1; restart = 1'b0;
    check("wa_restart_fail", fail_led, 0);
    check("wa_restart_lost", align_lost, 0);
    check("wa_restart_bad", bad_cnt, 0);

    // Reset asserted mid-frame abandons the frame
    do_reset();
    wait_rx();
    tvalid = 1'b1; tkeep = '1; tdata = '0;
    repeat (3) begin @(posedge clk); #1; end
    tlast = 1'b1; tkeep = 64'h3FF;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_state", rx_prestate, 0);
    check("midrst_counts", {good_cnt, bad_cnt}, 0);
    idle_inputs();
    rst = 1'b0;
    good_frame();
    check("midrst_after_good", good_cnt, 1);
    check("midrst_after_bad", bad_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
